fabric_config_loader: RTL

Byte-stream configuration writer for fabric_2x2. It receives a framed bitstream (sync, payload, checksum) over a valid/ready byte interface and verifies it. On success it commits the payload atomically to the 52-bit config_bits bus, then holds the fabric in reset for a fixed window so CLB flip-flops restart cleanly. It sits between the host/SPI byte source and the fabric's parallel config_bits and rst_n inputs.

---
 rtl/fabric_cfg_pkg.sv | 56 +++++
 rtl/cfg_frame_checker.sv | 67 ++++++
 rtl/fabric_config_loader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fabric_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fabric_cfg_pkg
// Shared constants and types for the fabric_2x2 configuration loader.
//   - CLB geometry (4 CLBs x 13 config bits) and per-CLB field offsets
//   - frame constants (sync marker, payload length, timeout, fabric reset window)
//   - err_code encodings and the loader state enum
// -----------------------------------------------------------------------------
package fabric_cfg_pkg;

    // Fabric geometry
    localparam int CLB_CFG_W  = 13;
    localparam int NUM_CLBS   = 4;
    localparam int CFG_WIDTH  = CLB_CFG_W * NUM_CLBS;
    localparam int NUM_BYTES  = (CFG_WIDTH + 7) / 8;
    localparam int BYTE_CNT_W = $clog2(NUM_BYTES);

    // Field layout inside one CLB's 13-bit slice
    localparam int CLB_MODE_LSB  = 0;
    localparam int CLB_MODE_W    = 2;
    localparam int CLB_ASEL_LSB  = 2;
    localparam int CLB_ASEL_W    = 3;
    localparam int CLB_BSEL_LSB  = 5;
    localparam int CLB_BSEL_W    = 3;
    localparam int CLB_ROUTE_LSB = 8;
    localparam int CLB_ROUTE_W   = 4;
    localparam int CLB_USEFF_BIT = 12;

    // Framing
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int TIMEOUT_CYCLES    = 255;
    localparam int IDLE_CNT_W        = $clog2(TIMEOUT_CYCLES);
    localparam int FABRIC_RST_CYCLES = 4;
    localparam int HOLD_CNT_W        = $clog2(FABRIC_RST_CYCLES);

    // Error codes reported on err_code
    typedef logic [1:0] err_code_t;
    localparam err_code_t ERR_NONE     = 2'b00;
    localparam err_code_t ERR_CHECKSUM = 2'b01;
    localparam err_code_t ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_HOLD    = 2'd3
    } cfg_state_e;

    // Extract the 13-bit configuration slice of CLB number idx
    function automatic logic [CLB_CFG_W-1:0] clb_slice(
        input logic [CFG_WIDTH-1:0] cfg,
        input int                   idx
    );
        return cfg[idx*CLB_CFG_W +: CLB_CFG_W];
    endfunction

endpackage

// File: rtl/cfg_frame_checker.sv
// -----------------------------------------------------------------------------
// cfg_frame_checker
// Frame bookkeeping for the config loader: payload byte counter, running XOR
// checksum and the inter-byte idle (timeout) counter.
// Ports:
//   clk, rst_n    clock / async active-low reset
//   frame_start   sync byte accepted: clear counter, checksum and idle count
//   payload_en    payload byte accepted this cycle (data is valid)
//   xfer          any byte accepted this cycle
//   armed         a frame is in progress (idle counter runs)
//   data          byte on the input interface
//   byte_cnt      index of the next payload byte
//   xor_acc       XOR of all payload bytes received so far
//   last_byte     byte_cnt points at the final payload byte
//   timeout       idle limit reached this cycle with no transfer
// -----------------------------------------------------------------------------
module cfg_frame_checker
    import fabric_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  payload_en,
    input  logic                  xfer,
    input  logic                  armed,
    input  logic [7:0]            data,
    output logic [BYTE_CNT_W-1:0] byte_cnt,
    output logic [7:0]            xor_acc,
    output logic                  last_byte,
    output logic                  timeout
);

    logic [BYTE_CNT_W-1:0] byte_cnt_reg;
    logic [7:0]            xor_acc_reg;
    logic [IDLE_CNT_W-1:0] idle_cnt_reg;

    // idle_cnt counts completed idle cycles; the cycle that would make it
    // TIMEOUT_CYCLES is the one that fires.
    assign timeout   = armed && !xfer &&
                       (idle_cnt_reg == IDLE_CNT_W'(TIMEOUT_CYCLES - 1));
    assign last_byte = (byte_cnt_reg == BYTE_CNT_W'(NUM_BYTES - 1));
    assign byte_cnt  = byte_cnt_reg;
    assign xor_acc   = xor_acc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_reg <= '0;
            xor_acc_reg  <= '0;
            idle_cnt_reg <= '0;
        end else if (frame_start) begin
            byte_cnt_reg <= '0;
            xor_acc_reg  <= '0;
            idle_cnt_reg <= '0;
        end else begin
            if (payload_en) begin
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
                xor_acc_reg  <= xor_acc_reg ^ data;
            end
            if (xfer) begin
                idle_cnt_reg <= '0;
            end else if (armed) begin
                idle_cnt_reg <= timeout ? '0 : idle_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fabric_config_loader.sv
// -----------------------------------------------------------------------------
// fabric_config_loader
// Receives a framed configuration bitstream (sync, NUM_BYTES payload bytes
// LSB-first, XOR checksum) over a valid/ready byte interface. A frame with a
// matching checksum is committed atomically to config_bits, after which the
// fabric is held in reset for FABRIC_RST_CYCLES cycles.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   in_data        bitstream byte
//   in_valid       byte present
//   in_ready       loader accepts a byte (transfer = in_valid & in_ready)
//   config_bits    committed configuration to the fabric
//   cfg_loaded     at least one frame committed since reset
//   fabric_rst_n   active-low reset to the fabric
//   busy           frame in progress or fabric reset window active
//   cfg_done       one-cycle pulse on commit
//   cfg_err        one-cycle pulse on rejected frame
//   err_code       reason of last rejection, cleared by the next sync byte
// -----------------------------------------------------------------------------
module fabric_config_loader
    import fabric_cfg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CFG_WIDTH-1:0] config_bits,
    output logic                 cfg_loaded,
    output logic                 fabric_rst_n,
    output logic                 busy,
    output logic                 cfg_done,
    output logic                 cfg_err,
    output logic [1:0]           err_code
);

    cfg_state_e            state_reg, state_next;
    logic                  started_reg;
    logic [CFG_WIDTH-1:0]  config_bits_reg, config_bits_next;
    logic [CFG_WIDTH-1:0]  shadow_bits;
    logic                  cfg_loaded_reg, cfg_loaded_next;
    logic                  fabric_rst_n_reg, fabric_rst_n_next;
    logic                  cfg_done_reg, cfg_done_next;
    logic                  cfg_err_reg, cfg_err_next;
    err_code_t             err_code_reg, err_code_next;
    logic [HOLD_CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

    logic                  xfer;
    logic                  frame_start;
    logic                  payload_en;
    logic                  armed;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [7:0]            xor_acc;
    logic                  last_byte;
    logic                  timeout;

    // started_reg keeps the interface closed during the first cycle after
    // reset release so nothing is accepted while reset is still settling.
    assign in_ready     = started_reg && (state_reg != ST_HOLD);
    assign xfer         = in_valid && in_ready;
    assign armed        = (state_reg == ST_PAYLOAD) || (state_reg == ST_CHECK);
    assign busy         = (state_reg != ST_IDLE);
    assign config_bits  = config_bits_reg;
    assign cfg_loaded   = cfg_loaded_reg;
    assign fabric_rst_n = fabric_rst_n_reg;
    assign cfg_done     = cfg_done_reg;
    assign cfg_err      = cfg_err_reg;
    assign err_code     = err_code_reg;

    cfg_frame_checker u_checker (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .payload_en  (payload_en),
        .xfer        (xfer),
        .armed       (armed),
        .data        (in_data),
        .byte_cnt    (byte_cnt),
        .xor_acc     (xor_acc),
        .last_byte   (last_byte),
        .timeout     (timeout)
    );

    // Shadow register, one lane per payload byte. The top lane keeps only the
    // bits that fit in CFG_WIDTH; the excess payload bits are dropped here.
    genvar gi;
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
        localparam int LO = 8 * gi;
        localparam int W  = ((CFG_WIDTH - LO) < 8) ? (CFG_WIDTH - LO) : 8;
        logic [W-1:0] lane_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_reg <= '0;
            end else if (payload_en && (byte_cnt == BYTE_CNT_W'(gi))) begin
                lane_reg <= in_data[W-1:0];
            end
        end

        assign shadow_bits[LO +: W] = lane_reg;
    end

    always_comb begin
        state_next        = state_reg;
        config_bits_next  = config_bits_reg;
        cfg_loaded_next   = cfg_loaded_reg;
        fabric_rst_n_next = 1'b1;
        cfg_done_next     = 1'b0;
        cfg_err_next      = 1'b0;
        err_code_next     = err_code_reg;
        hold_cnt_next     = hold_cnt_reg;
        frame_start       = 1'b0;
        payload_en        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (xfer && (in_data == SYNC_BYTE)) begin
                    frame_start   = 1'b1;
                    err_code_next = ERR_NONE;
                    state_next    = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                if (timeout) begin
                    cfg_err_next  = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                    state_next    = ST_IDLE;
                end else if (xfer) begin
                    payload_en = 1'b1;
                    if (last_byte) begin
                        state_next = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (timeout) begin
                    cfg_err_next  = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                    state_next    = ST_IDLE;
                end else if (xfer) begin
                    if (in_data == xor_acc) begin
                        config_bits_next  = shadow_bits;
                        cfg_done_next     = 1'b1;
                        cfg_loaded_next   = 1'b1;
                        fabric_rst_n_next = 1'b0;
                        hold_cnt_next     = '0;
                        state_next        = ST_HOLD;
                    end else begin
                        cfg_err_next  = 1'b1;
                        err_code_next = ERR_CHECKSUM;
                        state_next    = ST_IDLE;
                    end
                end
            end

            ST_HOLD: begin
                // Commit edge already drove fabric_rst_n low; HOLD spans the
                // remaining cycles so the low window is FABRIC_RST_CYCLES long.
                if (hold_cnt_reg == HOLD_CNT_W'(FABRIC_RST_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    fabric_rst_n_next = 1'b0;
                    hold_cnt_next     = hold_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            started_reg      <= 1'b0;
            config_bits_reg  <= '0;
            cfg_loaded_reg   <= 1'b0;
            fabric_rst_n_reg <= 1'b0;
            cfg_done_reg     <= 1'b0;
            cfg_err_reg      <= 1'b0;
            err_code_reg     <= ERR_NONE;
            hold_cnt_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            started_reg      <= 1'b1;
            config_bits_reg  <= config_bits_next;
            cfg_loaded_reg   <= cfg_loaded_next;
            fabric_rst_n_reg <= fabric_rst_n_next;
            cfg_done_reg     <= cfg_done_next;
            cfg_err_reg      <= cfg_err_next;
            err_code_reg     <= err_code_next;
            hold_cnt_reg     <= hold_cnt_next;
        end
    end

endmodule
